// File: rtl/raster_plot_sink.sv
`default_nettype none
// ============================================================================
// Module      : raster_plot_sink
// Description : Three-stage plot sink for the raster scanners. A request is
//               taken in stage A, which issues its ROM address. Stage F waits
//               while the synchronous image ROM returns the colour word.
//               Stage O drives the shared VGA plot port and waits for
//               vga_grant. Off-screen pixels flow through O without plotting.
//               frame_done pulses once after the last pixel of a frame leaves O.
//
//               Build macro TRANSPARENT_KEY_EN: when it is defined, pixels
//               whose fetched colour equals KEY_COLOR are treated as
//               invisible. By default the macro is undefined.
//
// Ports       : CLK          clock
//               resetn       synchronous, active-low reset
//               in_valid     request present
//               in_ready     request accepted when in_valid is also high
//               in_x/in_y    pixel coordinates
//               in_addr      image ROM address of the pixel
//               in_last      final pixel of the frame
//               rom_addr     registered ROM address
//               rom_data     ROM word, valid one edge after rom_addr
//               plot         pixel write request
//               plot_x/_y    write coordinates
//               plot_colour  write colour
//               vga_grant    write performed when plot is also high
//               frame_done   one-cycle pulse after the last pixel completes
//
// Revision    : 1.0 - initial release
// ============================================================================
module raster_plot_sink #(
  parameter logic [7:0]         X_MAX     = 8'd159,
  parameter logic [6:0]         Y_MAX     = 7'd119,
  parameter int                 ADDR_W    = 15,
  parameter int                 COLOR_W   = 3,
  parameter logic [COLOR_W-1:0] KEY_COLOR = '0
) (
  input  logic               CLK,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_x,
  input  logic [6:0]         in_y,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic               in_last,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic               plot,
  output logic [7:0]         plot_x,
  output logic [6:0]         plot_y,
  output logic [COLOR_W-1:0] plot_colour,
  input  logic               vga_grant,
  output logic               frame_done
);

  // Stage A: address issued
  logic               r_a_valid;
  logic [7:0]         r_a_x;
  logic [6:0]         r_a_y;
  logic               r_a_last;
  logic               r_a_vis;

  // Stage F: ROM sampling
  logic               r_f_valid;
  logic [7:0]         r_f_x;
  logic [6:0]         r_f_y;
  logic               r_f_last;
  logic               r_f_vis;

  // Stage O: output (x/y/colour live directly in the plot_* registers)
  logic               r_o_valid;
  logic               r_o_last;
  logic               r_o_vis;

  // Skid register: while stalled, the ROM keeps re-reading A's address, so
  // F's own word must be captured on the first stalled edge or it is lost.
  logic [COLOR_W-1:0] r_skid;
  logic               r_skid_full;
  logic               r_frame_done;

  logic               w_stall;
  logic               w_vis_in;
  logic               w_complete;
  logic [COLOR_W-1:0] w_f_colour;
  logic               w_o_vis_next;

  assign plot       = r_o_valid && r_o_vis;
  assign w_stall    = plot && !vga_grant;
  assign in_ready   = !w_stall;
  assign w_complete = r_o_valid && !w_stall;
  assign frame_done = r_frame_done;

  // Unsigned compare at full port width: x values above X_MAX (up to 255)
  // are off-screen.
  assign w_vis_in   = (in_x <= X_MAX) && (in_y <= Y_MAX);

  // F's colour: the live ROM word unless a stall forced it into the skid.
  assign w_f_colour = r_skid_full ? r_skid : rom_data;

`ifdef TRANSPARENT_KEY_EN
  assign w_o_vis_next = r_f_vis && (w_f_colour != KEY_COLOR);
`else
  assign w_o_vis_next = r_f_vis;
  logic w_unused_key;
  assign w_unused_key = ^KEY_COLOR;
`endif

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      r_a_valid    <= 1'b0;
      r_a_x        <= '0;
      r_a_y        <= '0;
      r_a_last     <= 1'b0;
      r_a_vis      <= 1'b0;
      rom_addr     <= '0;
      r_f_valid    <= 1'b0;
      r_f_x        <= '0;
      r_f_y        <= '0;
      r_f_last     <= 1'b0;
      r_f_vis      <= 1'b0;
      r_o_valid    <= 1'b0;
      r_o_last     <= 1'b0;
      r_o_vis      <= 1'b0;
      plot_x       <= '0;
      plot_y       <= '0;
      plot_colour  <= '0;
      r_skid       <= '0;
      r_skid_full  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_complete && r_o_last;

      if (!w_stall) begin
        // in_ready is high here, so any valid request is accepted
        r_a_valid <= in_valid;
        if (in_valid) begin
          r_a_x    <= in_x;
          r_a_y    <= in_y;
          r_a_last <= in_last;
          r_a_vis  <= w_vis_in;
          rom_addr <= in_addr;
        end

        r_f_valid <= r_a_valid;
        r_f_x     <= r_a_x;
        r_f_y     <= r_a_y;
        r_f_last  <= r_a_last;
        r_f_vis   <= r_a_vis;

        r_o_valid   <= r_f_valid;
        r_o_last    <= r_f_last;
        r_o_vis     <= w_o_vis_next;
        plot_x      <= r_f_x;
        plot_y      <= r_f_y;
        plot_colour <= w_f_colour;

        r_skid_full <= 1'b0;
      end else if (!r_skid_full) begin
        r_skid      <= rom_data;
        r_skid_full <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_raster_plot_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_raster_plot_sink
// Description : Directed self-checking bench for raster_plot_sink. The image
//               ROM model returns addr[2:0] one edge after sampling rom_addr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_raster_plot_sink;

  logic        CLK = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [14:0] in_addr;
  logic        in_last;
  logic [14:0] rom_addr;
  logic [2:0]  rom_data;
  logic        plot;
  logic [7:0]  plot_x;
  logic [6:0]  plot_y;
  logic [2:0]  plot_colour;
  logic        vga_grant;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  // Writes seen on the plot port: {y, x, colour}
  logic [17:0] wr_q[$];
  int          fd_count = 0;

  raster_plot_sink dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_addr     (in_addr),
    .in_last     (in_last),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .plot        (plot),
    .plot_x      (plot_x),
    .plot_y      (plot_y),
    .plot_colour (plot_colour),
    .vga_grant   (vga_grant),
    .frame_done  (frame_done)
  );

  always #5 CLK = ~CLK;

  // Synchronous ROM: word = addr[2:0]
  always @(posedge CLK) rom_data <= rom_addr[2:0];

  // Inputs change at posedge+1, so the negedge sees what the next edge uses.
  always @(negedge CLK) begin
    if (resetn && plot && vga_grant) wr_q.push_back({plot_y, plot_x, plot_colour});
    if (frame_done) fd_count++;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [7:0] x, input logic [6:0] y,
                         input logic [14:0] a, input logic l);
    in_valid = v;
    in_x     = x;
    in_y     = y;
    in_addr  = a;
    in_last  = l;
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    vga_grant = 1'b1;
    set_req(1'b1, 8'd3, 7'd1, 15'd5, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (plot !== 1'b0) begin bad++; $display("FAIL reset_plot cyc%0d: got %b want 0", i, plot); end
      total++; if (rom_addr !== 15'd0) begin bad++; $display("FAIL reset_rom_addr cyc%0d: got %0d want 0", i, rom_addr); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done cyc%0d: got %b want 0", i, frame_done); end
    end
    resetn = 1'b1;
    set_req(1'b0, 8'd0, 7'd0, 15'd0, 1'b0);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) step();
    total++; if (wr_q.size() != 0) begin bad++; $display("FAIL reset_no_consume: got %0d writes want 0", wr_q.size()); end
    total++; if (fd_count != 0) begin bad++; $display("FAIL reset_no_frame_done: got %0d pulses want 0", fd_count); end
  endtask

  task automatic test_stream();
    logic [7:0] ex [3];
    logic [2:0] ec [3];
    ex[0] = 8'd0; ex[1] = 8'd1; ex[2] = 8'd2;
    ec[0] = 3'd5; ec[1] = 3'd6; ec[2] = 3'd7;
    wr_q.delete();
    vga_grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 8'(i), 7'd0, 15'(5 + i), i == 2);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready%0d: got %b want 1", i, in_ready); end
      step();
    end
    set_req(1'b0, 8'd0, 7'd0, 15'd0, 1'b0);
    // Now just after edge k+2: O holds the first pixel.
    for (int i = 0; i < 3; i++) begin
      total++;
      if (plot !== 1'b1 || plot_x !== ex[i] || plot_colour !== ec[i] || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL stream_pix%0d: got plot=%b x=%0d c=%0d fd=%b want plot=1 x=%0d c=%0d fd=0",
                 i, plot, plot_x, plot_colour, frame_done, ex[i], ec[i]);
      end
      step();
    end
    // Last pixel was written at the previous edge.
    total++; if (plot !== 1'b0 || frame_done !== 1'b1) begin bad++; $display("FAIL stream_done: got plot=%b fd=%b want plot=0 fd=1", plot, frame_done); end
    step();
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL stream_done_width: got fd=%b want 0", frame_done); end
    total++; if (wr_q.size() != 3) begin bad++; $display("FAIL stream_count: got %0d writes want 3", wr_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [7:0] hx;
    logic [2:0] hc;
    int n;
    wr_q.delete();
    vga_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 8'(20 + i), 7'd4, 15'(1 + i), 1'b0);
      step();
    end
    // First write happened at this edge; grant now drops for 3 cycles.
    set_req(1'b0, 8'd0, 7'd0, 15'd0, 1'b0);
    vga_grant = 1'b0;
    #1;
    hx = plot_x;
    hc = plot_colour;
    total++; if (hx !== 8'd21 || hc !== 3'd2) begin bad++; $display("FAIL bp_held_entry: got x=%0d c=%0d want x=21 c=2", hx, hc); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (in_ready !== 1'b0 || plot !== 1'b1 || plot_x !== hx || plot_colour !== hc) begin
        bad++;
        $display("FAIL bp_stall%0d: got rdy=%b plot=%b x=%0d c=%0d want rdy=0 plot=1 x=%0d c=%0d",
                 i, in_ready, plot, plot_x, plot_colour, hx, hc);
      end
      step();
    end
    vga_grant = 1'b1;
    n = 0;
    while (wr_q.size() < 4 && n < 20) begin step(); n++; end
    for (int i = 0; i < 3; i++) step();
    total++; if (wr_q.size() != 4) begin bad++; $display("FAIL bp_count: got %0d writes want 4", wr_q.size()); end
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      total++;
      if (wr_q[i][2:0] !== 3'(1 + i) || wr_q[i][10:3] !== 8'(20 + i)) begin
        bad++;
        $display("FAIL bp_order%0d: got x=%0d c=%0d want x=%0d c=%0d", i, wr_q[i][10:3], wr_q[i][2:0], 20 + i, 1 + i);
      end
    end
  endtask

  task automatic test_clipping();
    wr_q.delete();
    fd_count  = 0;
    vga_grant = 1'b1;
    set_req(1'b1, 8'd160, 7'd0,   15'd1, 1'b0); step();
    set_req(1'b1, 8'd0,   7'd120, 15'd2, 1'b1); step();
    set_req(1'b1, 8'd159, 7'd119, 15'd3, 1'b0); step();
    set_req(1'b0, 8'd0, 7'd0, 15'd0, 1'b0);
    total++; if (plot !== 1'b0) begin bad++; $display("FAIL clip_x: got plot=%b want 0", plot); end
    step();
    total++; if (plot !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("FAIL clip_y: got plot=%b fd=%b want 0 0", plot, frame_done); end
    step();
    total++;
    if (plot !== 1'b1 || plot_x !== 8'd159 || plot_y !== 7'd119 || plot_colour !== 3'd3 || frame_done !== 1'b1) begin
      bad++;
      $display("FAIL clip_corner: got plot=%b x=%0d y=%0d c=%0d fd=%b want 1 159 119 3 fd=1",
               plot, plot_x, plot_y, plot_colour, frame_done);
    end
    for (int i = 0; i < 3; i++) step();
    total++; if (wr_q.size() != 1 || fd_count != 1) begin bad++; $display("FAIL clip_totals: got writes=%0d pulses=%0d want 1 1", wr_q.size(), fd_count); end
  endtask

  task automatic test_key();
    vga_grant = 1'b0;
    set_req(1'b1, 8'd5, 7'd5, 15'd8, 1'b0); step();
    set_req(1'b0, 8'd0, 7'd0, 15'd0, 1'b0); step(); step();
`ifdef TRANSPARENT_KEY_EN
    total++; if (plot !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL key_hidden: got plot=%b rdy=%b want 0 1", plot, in_ready); end
`else
    total++;
    if (plot !== 1'b1 || plot_colour !== 3'd0 || plot_x !== 8'd5 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL key_plotted: got plot=%b c=%0d x=%0d rdy=%b want 1 0 5 0", plot, plot_colour, plot_x, in_ready);
    end
`endif
    vga_grant = 1'b1;
    step();
    total++; if (plot !== 1'b0) begin bad++; $display("FAIL key_drain: got plot=%b want 0", plot); end
  endtask

  task automatic test_reset_mid_stall();
    vga_grant = 1'b0;
    set_req(1'b1, 8'd7, 7'd3, 15'd6, 1'b1); step();
    set_req(1'b0, 8'd0, 7'd0, 15'd0, 1'b0); step(); step(); step();
    total++; if (plot !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL mid_stall_setup: got plot=%b rdy=%b want 1 0", plot, in_ready); end
    fd_count = 0;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    #1;
    total++; if (plot !== 1'b0 || in_ready !== 1'b1 || frame_done !== 1'b0) begin bad++; $display("FAIL mid_stall_reset: got plot=%b rdy=%b fd=%b want 0 1 0", plot, in_ready, frame_done); end
    vga_grant = 1'b1;
    for (int i = 0; i < 3; i++) step();
    total++; if (fd_count != 0) begin bad++; $display("FAIL mid_stall_no_pulse: got %0d pulses want 0", fd_count); end
    set_req(1'b1, 8'd9, 7'd2, 15'd3, 1'b0); step();
    set_req(1'b0, 8'd0, 7'd0, 15'd0, 1'b0);
    step();
    total++; if (plot !== 1'b0) begin bad++; $display("FAIL fresh_early: got plot=%b want 0", plot); end
    step();
    total++;
    if (plot !== 1'b1 || plot_x !== 8'd9 || plot_y !== 7'd2 || plot_colour !== 3'd3) begin
      bad++;
      $display("FAIL fresh_plot: got plot=%b x=%0d y=%0d c=%0d want 1 9 2 3", plot, plot_x, plot_y, plot_colour);
    end
    step();
  endtask

  initial begin
    set_req(1'b0, 8'd0, 7'd0, 15'd0, 1'b0);
    resetn    = 1'b0;
    vga_grant = 1'b0;
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_clipping();
    test_key();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
